// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: op codes, FSM states and reset defaults shared by the memory stage.
package mem_stage_pkg;
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_PUSH   = 3'd3,
    OP_POP    = 3'd4,
    OP_PUSH32 = 3'd5,
    OP_POP32  = 3'd6
  } op_e;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;
  localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFF;
  localparam int ADDR_W_DEFAULT = 16;
endpackage

// File: rtl/mem_stage_controller_if.sv
// mem_stage_controller_if: EX/MEM request, data-memory and result signals of the memory stage.
interface mem_stage_controller_if;
  import mem_stage_pkg::*;
  logic        i_valid;
  op_e         i_op;
  logic [15:0] i_address;
  logic [15:0] i_write_data;
  logic [31:0] i_write_data32;
  logic [15:0] i_read_data;
  logic [15:0] o_address;
  logic [15:0] o_write_data;
  logic        o_memory_read;
  logic        o_memory_write;
  logic        o_stall;
  logic        o_result_valid;
  logic [31:0] o_result;
  logic [15:0] o_sp;
  logic        o_stack_fault;
  modport slave (
    input  i_valid, i_op, i_address, i_write_data, i_write_data32, i_read_data,
    output o_address, o_write_data, o_memory_read, o_memory_write, o_stall,
           o_result_valid, o_result, o_sp, o_stack_fault
  );
  modport master (
    output i_valid, i_op, i_address, i_write_data, i_write_data32, i_read_data,
    input  o_address, o_write_data, o_memory_read, o_memory_write, o_stall,
           o_result_valid, o_result, o_sp, o_stack_fault
  );
endinterface

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: SP register, stack address generation and optional bounds check.
// Bounds checking is compiled in with MEM_STAGE_STACK_CHECK_EN.
module stack_pointer_unit
  import mem_stage_pkg::*;
#(
  parameter int                 ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]  SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  op_e               i_op,
  input  state_e            i_state,
  output logic [ADDR_W-1:0] o_sp,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_fault,
  output logic              o_stack_fault
);
  logic [ADDR_W-1:0] r_sp, w_delta;
  logic w_push, w_pop, w_wide, w_second, w_update;
  assign w_push   = i_op == OP_PUSH || i_op == OP_PUSH32;
  assign w_pop    = i_op == OP_POP || i_op == OP_POP32;
  assign w_wide   = i_op == OP_PUSH32 || i_op == OP_POP32;
  assign w_second = i_state == ST_SECOND;
  assign w_delta  = w_second ? ADDR_W'(2) : ADDR_W'(1);
  assign o_address = w_pop ? r_sp + w_delta : (w_second ? r_sp - ADDR_W'(1) : r_sp);
  // 32-bit ops move SP only once, in their second cycle
  assign w_update = i_valid && !o_fault && (w_push || w_pop) && (w_wide == w_second);
  assign o_sp = r_sp;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sp <= SP_RESET;
    else if (w_update) r_sp <= w_push ? r_sp - w_delta : r_sp + w_delta;
  end
`ifdef MEM_STAGE_STACK_CHECK_EN
  logic [ADDR_W:0] w_span;
  logic r_fault;
  assign w_span  = w_wide ? (ADDR_W+1)'(1) : '0;
  assign o_fault = i_valid && !w_second &&
                   ((w_push && {1'b0, r_sp} < w_span) ||
                    (w_pop && {1'b0, r_sp} + w_span + (ADDR_W+1)'(1) > {1'b0, SP_RESET}));
  always_ff @(posedge i_clk) begin
    if (i_reset) r_fault <= 1'b0;
    else if (o_fault) r_fault <= 1'b1;
  end
  assign o_stack_fault = r_fault;
`else
  assign o_fault       = 1'b0;
  assign o_stack_fault = 1'b0;
`endif
endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: memory-stage sequencer, splits 32-bit stack ops into two 16-bit accesses.
// Optional stack bounds checking with MEM_STAGE_STACK_CHECK_EN.
module mem_stage_controller
  import mem_stage_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input logic             i_clk,
  input logic             i_reset,
  mem_stage_controller_if.slave bus
);
  state_e r_state, w_next;
  logic [15:0] r_high;
  logic [31:0] r_result;
  logic r_result_valid;
  logic [ADDR_W-1:0] w_sp, w_sp_addr;
  logic w_go, w_fault, w_stack, w_rd, w_wr, w_stall, w_res;
  logic [15:0] w_rdata;
  op_e w_op;
  assign w_op    = bus.i_op;
  assign w_go    = bus.i_valid && !i_reset && w_op != OP_NONE;
  assign w_stack = w_op inside {OP_PUSH, OP_POP, OP_PUSH32, OP_POP32};
  assign w_rdata = w_fault ? 16'h0 : bus.i_read_data;
  stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_spu (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (w_go),
    .i_op          (w_op),
    .i_state       (r_state),
    .o_sp          (w_sp),
    .o_address     (w_sp_addr),
    .o_fault       (w_fault),
    .o_stack_fault (bus.o_stack_fault)
  );
  always_comb begin
    w_rd    = w_go && !w_fault && w_op inside {OP_LOAD, OP_POP, OP_POP32};
    w_wr    = w_go && !w_fault && w_op inside {OP_STORE, OP_PUSH, OP_PUSH32};
    w_stall = w_go && !w_fault && r_state == ST_IDLE && w_op inside {OP_PUSH32, OP_POP32};
    w_next  = w_stall ? ST_SECOND : ST_IDLE;
    w_res   = w_go && (w_op inside {OP_LOAD, OP_POP} ||
                       (w_op == OP_POP32 && (r_state == ST_SECOND || w_fault)));
  end
  assign bus.o_address      = w_stack ? w_sp_addr : bus.i_address;
  assign bus.o_write_data   = r_state == ST_SECOND ? bus.i_write_data32[31:16] :
                              w_op == OP_PUSH32 ? bus.i_write_data32[15:0] : bus.i_write_data;
  assign bus.o_memory_read  = w_rd;
  assign bus.o_memory_write = w_wr;
  assign bus.o_stall        = w_stall;
  assign bus.o_result_valid = r_result_valid;
  assign bus.o_result       = r_result;
  assign bus.o_sp           = w_sp;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // first POP32 read is the high half; it is paired with the low half next cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_high         <= '0;
    end else begin
      r_result_valid <= w_res;
      if (w_res) r_result <= (w_op == OP_POP32 && r_state == ST_SECOND) ? {r_high, w_rdata} : {16'h0, w_rdata};
      if (w_stall && w_op == OP_POP32) r_high <= bus.i_read_data;
    end
  end
endmodule

// File: tb/tb_mem_stage_controller.sv
// tb_mem_stage_controller: directed checks of the memory-stage sequencer against a behavioural data memory.
module tb_mem_stage_controller;
  import mem_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] mem [0:65535];
  mem_stage_controller_if bus();
  mem_stage_controller dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.i_read_data = mem[bus.o_address];
  always @(posedge clk) if (bus.o_memory_write) mem[bus.o_address] <= bus.o_write_data;

  task automatic drive(input op_e op, input logic [15:0] a, input logic [15:0] wd, input logic [31:0] wd32);
    @(negedge clk);
    bus.i_valid = op != OP_NONE;
    bus.i_op = op;
    bus.i_address = a;
    bus.i_write_data = wd;
    bus.i_write_data32 = wd32;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(OP_NONE, 16'h0, 16'h0, 32'h0);
    edge_settle();
    edge_settle();
    checks++; if (bus.o_sp !== 16'hFFFF) begin failures++; $display("FAIL reset_sp got=%h exp=ffff", bus.o_sp); end
    checks++; if (bus.o_result_valid !== 1'b0 || bus.o_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%b/%h exp=0/00000000", bus.o_result_valid, bus.o_result); end
    checks++; if ({bus.o_memory_read, bus.o_memory_write, bus.o_stall, bus.o_stack_fault} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {bus.o_memory_read, bus.o_memory_write, bus.o_stall, bus.o_stack_fault}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_push_pop();
    drive(OP_PUSH, 16'h0, 16'h1234, 32'h0);
    checks++; if (bus.o_memory_write !== 1'b1 || bus.o_address !== 16'hFFFF || bus.o_write_data !== 16'h1234) begin failures++; $display("FAIL push_access got=%b/%h/%h exp=1/ffff/1234", bus.o_memory_write, bus.o_address, bus.o_write_data); end
    edge_settle();
    checks++; if (bus.o_sp !== 16'hFFFE) begin failures++; $display("FAIL push_sp got=%h exp=fffe", bus.o_sp); end
    drive(OP_POP, 16'h0, 16'h0, 32'h0);
    checks++; if (bus.o_memory_read !== 1'b1 || bus.o_memory_write !== 1'b0 || bus.o_address !== 16'hFFFF) begin failures++; $display("FAIL pop_access got=%b%b/%h exp=10/ffff", bus.o_memory_read, bus.o_memory_write, bus.o_address); end
    edge_settle();
    checks++; if (bus.o_result_valid !== 1'b1 || bus.o_result !== 32'h0000_1234) begin failures++; $display("FAIL pop_result got=%b/%h exp=1/00001234", bus.o_result_valid, bus.o_result); end
    checks++; if (bus.o_sp !== 16'hFFFF) begin failures++; $display("FAIL pop_sp got=%h exp=ffff", bus.o_sp); end
  endtask

  task automatic test_push32();
    drive(OP_PUSH32, 16'h0, 16'h0, 32'hAAAA_5555);
    checks++; if (bus.o_memory_write !== 1'b1 || bus.o_address !== 16'hFFFF || bus.o_write_data !== 16'h5555 || bus.o_stall !== 1'b1) begin failures++; $display("FAIL push32_first got=%b/%h/%h/%b exp=1/ffff/5555/1", bus.o_memory_write, bus.o_address, bus.o_write_data, bus.o_stall); end
    edge_settle();
    checks++; if (bus.o_sp !== 16'hFFFF) begin failures++; $display("FAIL push32_mid_sp got=%h exp=ffff", bus.o_sp); end
    @(negedge clk); #1;
    checks++; if (bus.o_memory_write !== 1'b1 || bus.o_address !== 16'hFFFE || bus.o_write_data !== 16'hAAAA || bus.o_stall !== 1'b0) begin failures++; $display("FAIL push32_second got=%b/%h/%h/%b exp=1/fffe/aaaa/0", bus.o_memory_write, bus.o_address, bus.o_write_data, bus.o_stall); end
    edge_settle();
    checks++; if (bus.o_sp !== 16'hFFFD) begin failures++; $display("FAIL push32_sp got=%h exp=fffd", bus.o_sp); end
  endtask

  task automatic test_pop32();
    drive(OP_POP32, 16'h0, 16'h0, 32'h0);
    checks++; if (bus.o_memory_read !== 1'b1 || bus.o_address !== 16'hFFFE || bus.o_stall !== 1'b1) begin failures++; $display("FAIL pop32_first got=%b/%h/%b exp=1/fffe/1", bus.o_memory_read, bus.o_address, bus.o_stall); end
    edge_settle();
    checks++; if (bus.o_result_valid !== 1'b0) begin failures++; $display("FAIL pop32_mid_valid got=%b exp=0", bus.o_result_valid); end
    @(negedge clk); #1;
    checks++; if (bus.o_memory_read !== 1'b1 || bus.o_address !== 16'hFFFF || bus.o_stall !== 1'b0) begin failures++; $display("FAIL pop32_second got=%b/%h/%b exp=1/ffff/0", bus.o_memory_read, bus.o_address, bus.o_stall); end
    edge_settle();
    checks++; if (bus.o_result_valid !== 1'b1 || bus.o_result !== 32'hAAAA_5555) begin failures++; $display("FAIL pop32_result got=%b/%h exp=1/aaaa5555", bus.o_result_valid, bus.o_result); end
    checks++; if (bus.o_sp !== 16'hFFFF) begin failures++; $display("FAIL pop32_sp got=%h exp=ffff", bus.o_sp); end
  endtask

  task automatic test_store_load();
    drive(OP_STORE, 16'h0010, 16'hBEEF, 32'h0);
    checks++; if (bus.o_memory_write !== 1'b1 || bus.o_address !== 16'h0010 || bus.o_write_data !== 16'hBEEF) begin failures++; $display("FAIL store_access got=%b/%h/%h exp=1/0010/beef", bus.o_memory_write, bus.o_address, bus.o_write_data); end
    edge_settle();
    drive(OP_LOAD, 16'h0010, 16'h0, 32'h0);
    checks++; if (bus.o_memory_read !== 1'b1 || bus.o_address !== 16'h0010) begin failures++; $display("FAIL load_access got=%b/%h exp=1/0010", bus.o_memory_read, bus.o_address); end
    edge_settle();
    checks++; if (bus.o_result_valid !== 1'b1 || bus.o_result !== 32'h0000_BEEF || bus.o_sp !== 16'hFFFF) begin failures++; $display("FAIL load_result got=%b/%h/%h exp=1/0000beef/ffff", bus.o_result_valid, bus.o_result, bus.o_sp); end
    drive(OP_NONE, 16'h0010, 16'h0, 32'h0);
    checks++; if (bus.o_memory_read !== 1'b0 || bus.o_memory_write !== 1'b0) begin failures++; $display("FAIL idle_strobes got=%b%b exp=00", bus.o_memory_read, bus.o_memory_write); end
    edge_settle();
    checks++; if (bus.o_result_valid !== 1'b0 || bus.o_result !== 32'h0000_BEEF) begin failures++; $display("FAIL idle_hold got=%b/%h exp=0/0000beef", bus.o_result_valid, bus.o_result); end
  endtask

  task automatic test_reset_second();
    drive(OP_PUSH32, 16'h0, 16'h0, 32'h1111_2222);
    edge_settle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.o_memory_write !== 1'b0 || bus.o_stall !== 1'b0) begin failures++; $display("FAIL rst_second_strobe got=%b/%b exp=0/0", bus.o_memory_write, bus.o_stall); end
    edge_settle();
    checks++; if (bus.o_sp !== 16'hFFFF || bus.o_result_valid !== 1'b0 || mem[16'hFFFE] !== 16'hAAAA) begin failures++; $display("FAIL rst_second_state got=%h/%b/%h exp=ffff/0/aaaa", bus.o_sp, bus.o_result_valid, mem[16'hFFFE]); end
    drive(OP_NONE, 16'h0, 16'h0, 32'h0);
    rst = 1'b0;
    #1;
    checks++; if (bus.o_stall !== 1'b0 || bus.o_memory_write !== 1'b0) begin failures++; $display("FAIL rst_second_idle got=%b/%b exp=0/0", bus.o_stall, bus.o_memory_write); end
  endtask

  task automatic test_wrap();
    drive(OP_POP, 16'h0, 16'h0, 32'h0);
`ifdef MEM_STAGE_STACK_CHECK_EN
    checks++; if (bus.o_memory_read !== 1'b0) begin failures++; $display("FAIL wrap_read got=%b exp=0", bus.o_memory_read); end
    edge_settle();
    checks++; if (bus.o_sp !== 16'hFFFF || bus.o_result !== 32'h0 || bus.o_stack_fault !== 1'b1) begin failures++; $display("FAIL wrap_fault got=%h/%h/%b exp=ffff/00000000/1", bus.o_sp, bus.o_result, bus.o_stack_fault); end
    drive(OP_NONE, 16'h0, 16'h0, 32'h0);
    edge_settle();
    checks++; if (bus.o_stack_fault !== 1'b1) begin failures++; $display("FAIL wrap_sticky got=%b exp=1", bus.o_stack_fault); end
`else
    checks++; if (bus.o_memory_read !== 1'b1 || bus.o_address !== 16'h0000) begin failures++; $display("FAIL wrap_read got=%b/%h exp=1/0000", bus.o_memory_read, bus.o_address); end
    edge_settle();
    checks++; if (bus.o_sp !== 16'h0000 || bus.o_result !== 32'h0000_0C0C || bus.o_stack_fault !== 1'b0) begin failures++; $display("FAIL wrap_nocheck got=%h/%h/%b exp=0000/00000c0c/0", bus.o_sp, bus.o_result, bus.o_stack_fault); end
`endif
    rst = 1'b1;
    drive(OP_NONE, 16'h0, 16'h0, 32'h0);
    edge_settle();
    checks++; if (bus.o_stack_fault !== 1'b0 || bus.o_sp !== 16'hFFFF) begin failures++; $display("FAIL wrap_reset got=%b/%h exp=0/ffff", bus.o_stack_fault, bus.o_sp); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    mem[16'h0000] = 16'h0C0C;
    bus.i_valid = 1'b0;
    bus.i_op = OP_NONE;
    bus.i_address = '0;
    bus.i_write_data = '0;
    bus.i_write_data32 = '0;
    test_reset();
    test_push_pop();
    test_push32();
    test_pop32();
    test_store_load();
    test_reset_second();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
